dot_product_accumulator: RTL and testbench

- Signed int8 × int8 multiply-accumulate stage that sits directly upstream of the integer-to-FP8 converter.
- Consumes a stream of activation/weight pairs and sums LEN products into an ACC_BITS signed result.
- Presents each finished sum on a held output register with a valid/ready handshake. The converter samples that register.
- Saturates so that the result is always safe for sign-magnitude conversion.

---
 rtl/dot_product_accumulator_if.sv | 32 +++
 rtl/dot_product_accumulator.sv | 114 +++++++++++
 tb/tb_dot_product_accumulator.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/dot_product_accumulator_if.sv
// Handshake bundle for the int8 dot-product accumulator.
// master drives the act/wgt pairs and out_ready. slave (the accumulator) drives
// in_ready, the registered result, the saturation flag and the debug term count.
interface dot_product_accumulator_if #(
  parameter int DATA_BITS = 8,
  parameter int ACC_BITS  = 20
);
  // Input stream: one activation/weight pair per accepted beat
  logic                        in_valid;
  logic                        in_ready;
  logic signed [DATA_BITS-1:0] act;
  logic signed [DATA_BITS-1:0] wgt;

  // Output register: finished dot product, held until consumed
  logic                        out_valid;
  logic                        out_ready;
  logic signed [ACC_BITS-1:0]  acc_out;
  logic                        sat_flag;

  // Debug: terms accepted so far for the vector in progress
  logic [7:0]                  term_cnt;

  modport master (
    output in_valid, act, wgt, out_ready,
    input  in_ready, out_valid, acc_out, sat_flag, term_cnt
  );

  modport slave (
    input  in_valid, act, wgt, out_ready,
    output in_ready, out_valid, acc_out, sat_flag, term_cnt
  );
endinterface

// File: rtl/dot_product_accumulator.sv
// Purpose: signed int8 x int8 multiply-accumulate over LEN terms, saturating to a symmetric range.
// Latency: result registered on the edge that accepts the final term; valid right after that edge.
// Backpressure: only the final term stalls, and only while the previous result is unconsumed.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-high; discards any partial vector and pending result
//   bus.slave  in_valid/in_ready/act/wgt input stream;
//              out_valid/out_ready/acc_out/sat_flag result register; term_cnt debug count
module dot_product_accumulator #(
  parameter int DATA_BITS = 8,
  parameter int ACC_BITS  = 20,
  parameter int LEN       = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  dot_product_accumulator_if.slave bus
);

  localparam int PROD_BITS = 2 * DATA_BITS;
  localparam int SUM_BITS  = ACC_BITS + 1;

  localparam logic [7:0] LAST_TERM = 8'(LEN - 1);

  // Symmetric clamp limits at the sum width: +/-(2^(ACC_BITS-1)-1).
  // The most-negative code is excluded so the converter can negate safely.
  localparam logic signed [SUM_BITS-1:0] SUM_MAX = {2'b00, {(ACC_BITS-1){1'b1}}};
  localparam logic signed [SUM_BITS-1:0] SUM_MIN = {2'b11, {(ACC_BITS-2){1'b0}}, 1'b1};

  localparam logic signed [ACC_BITS-1:0] ACC_MAX = {1'b0, {(ACC_BITS-1){1'b1}}};
  localparam logic signed [ACC_BITS-1:0] ACC_MIN = {1'b1, {(ACC_BITS-2){1'b0}}, 1'b1};

  // Architectural state
  logic signed [ACC_BITS-1:0] acc;
  logic [7:0]                 term_cnt;
  logic                       sticky;
  logic signed [ACC_BITS-1:0] acc_out;
  logic                       sat_flag;
  logic                       out_valid;

  // Datapath
  logic signed [PROD_BITS-1:0] product;
  logic signed [SUM_BITS-1:0]  sum;
  logic signed [ACC_BITS-1:0]  acc_next;
  logic                        clamp_now;

  logic is_final;
  logic in_ready;
  logic accept;

  assign is_final = (term_cnt == LAST_TERM);

  // A final term may push while the old result pops in the same cycle.
  assign in_ready = !(is_final && out_valid && !bus.out_ready);
  assign accept   = bus.in_valid && in_ready;

  assign product = bus.act * bus.wgt;

  // One extra bit of headroom: acc is within +/-(2^(ACC_BITS-1)-1) and the
  // product is far smaller, so the add can never wrap at SUM_BITS.
  assign sum = $signed({acc[ACC_BITS-1], acc})
             + $signed({{(SUM_BITS-PROD_BITS){product[PROD_BITS-1]}}, product});

  always_comb begin
    acc_next  = sum[ACC_BITS-1:0];
    clamp_now = 1'b0;
    if (sum > SUM_MAX) begin
      acc_next  = ACC_MAX;
      clamp_now = 1'b1;
    end else if (sum < SUM_MIN) begin
      acc_next  = ACC_MIN;
      clamp_now = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc       <= '0;
      term_cnt  <= '0;
      sticky    <= 1'b0;
      acc_out   <= '0;
      sat_flag  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      // Pop first; a same-edge final accept below overrides it back to 1.
      if (out_valid && bus.out_ready) begin
        out_valid <= 1'b0;
      end

      if (accept) begin
        if (is_final) begin
          acc_out   <= acc_next;
          sat_flag  <= sticky | clamp_now;
          out_valid <= 1'b1;
          acc       <= '0;
          term_cnt  <= '0;
          sticky    <= 1'b0;
        end else begin
          // Accumulation resumes from the clamped value, not the raw sum.
          acc      <= acc_next;
          term_cnt <= term_cnt + 8'd1;
          sticky   <= sticky | clamp_now;
        end
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.acc_out   = acc_out;
  assign bus.sat_flag  = sat_flag;
  assign bus.term_cnt  = term_cnt;

endmodule

// File: tb/tb_dot_product_accumulator.sv
module tb_dot_product_accumulator;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  dot_product_accumulator_if #(.DATA_BITS(8), .ACC_BITS(20)) b16  ();
  dot_product_accumulator_if #(.DATA_BITS(8), .ACC_BITS(20)) b256 ();
  dot_product_accumulator_if #(.DATA_BITS(8), .ACC_BITS(20)) b1   ();

  dot_product_accumulator #(.DATA_BITS(8), .ACC_BITS(20), .LEN(16)) dut16 (
    .clk(clk), .reset(reset), .bus(b16)
  );
  dot_product_accumulator #(.DATA_BITS(8), .ACC_BITS(20), .LEN(256)) dut256 (
    .clk(clk), .reset(reset), .bus(b256)
  );
  dot_product_accumulator #(.DATA_BITS(8), .ACC_BITS(20), .LEN(1)) dut1 (
    .clk(clk), .reset(reset), .bus(b1)
  );

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Present one pair on b16 for exactly one rising edge (caller knows in_ready is high).
  task automatic push16(input logic signed [7:0] a, input logic signed [7:0] w);
    b16.in_valid = 1'b1;
    b16.act      = a;
    b16.wgt      = w;
    @(negedge clk);
    b16.in_valid = 1'b0;
  endtask

  // Hold one pair on b256 for n consecutive rising edges.
  task automatic run256(input logic signed [7:0] a, input logic signed [7:0] w, input int n);
    b256.in_valid = 1'b1;
    b256.act      = a;
    b256.wgt      = w;
    repeat (n) @(negedge clk);
    b256.in_valid = 1'b0;
  endtask

  initial begin
    int pulses;
    int ready_lows;

    reset = 1'b1;
    b16.in_valid  = 1'b0; b16.act  = '0; b16.wgt  = '0; b16.out_ready  = 1'b1;
    b256.in_valid = 1'b0; b256.act = '0; b256.wgt = '0; b256.out_ready = 1'b1;
    b1.in_valid   = 1'b0; b1.act   = '0; b1.wgt   = '0; b1.out_ready   = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_out_valid", b16.out_valid, 0);
    chk("rst_acc_out",   $signed(b16.acc_out), 0);
    chk("rst_sat",       b16.sat_flag, 0);
    chk("rst_term_cnt",  b16.term_cnt, 0);
    chk("rst_in_ready",  b16.in_ready, 1);
    chk("rst256_valid",  b256.out_valid, 0);
    reset = 1'b0;
    @(negedge clk);

    // Reset mid-vector with a result pending
    b16.out_ready = 1'b0;
    repeat (16) push16(8'sd1, 8'sd1);
    chk("pend_valid", b16.out_valid, 1);
    chk("pend_acc",   $signed(b16.acc_out), 16);
    repeat (5) push16(8'sd3, 8'sd4);
    chk("mid_term_cnt", b16.term_cnt, 5);
    chk("mid_held_acc", $signed(b16.acc_out), 16);
    #2 reset = 1'b1;
    #1;
    chk("arst_term_cnt",  b16.term_cnt, 0);
    chk("arst_out_valid", b16.out_valid, 0);
    chk("arst_acc_out",   $signed(b16.acc_out), 0);
    chk("arst_sat",       b16.sat_flag, 0);
    @(negedge clk);
    reset = 1'b0;
    b16.out_ready = 1'b1;
    repeat (16) push16(8'sd1, 8'sd1);
    chk("post_rst_valid", b16.out_valid, 1);
    chk("post_rst_acc",   $signed(b16.acc_out), 16);
    chk("post_rst_sat",   b16.sat_flag, 0);

    // Signed mix: 8*(-16256) + 8*(-15) = -130168
    repeat (8) push16(-8'sd128, 8'sd127);
    repeat (7) push16(8'sd5, -8'sd3);
    chk("mix_pre_valid", b16.out_valid, 0);
    chk("mix_pre_cnt",   b16.term_cnt, 15);
    push16(8'sd5, -8'sd3);
    chk("mix_valid", b16.out_valid, 1);
    chk("mix_acc",   $signed(b16.acc_out), -130168);
    chk("mix_sat",   b16.sat_flag, 0);
    @(negedge clk);
    chk("mix_popped", b16.out_valid, 0);

    // Backpressure: result 32 held, next vector of (3,3) -> 144
    b16.out_ready = 1'b0;
    repeat (16) push16(8'sd1, 8'sd2);
    chk("bp_first_acc", $signed(b16.acc_out), 32);
    repeat (15) push16(8'sd3, 8'sd3);
    chk("bp_cnt15", b16.term_cnt, 15);
    b16.in_valid = 1'b1; b16.act = 8'sd3; b16.wgt = 8'sd3;
    #1;
    chk("bp_stall_rdy", b16.in_ready, 0);
    @(negedge clk);
    chk("bp_stall_cnt",   b16.term_cnt, 15);
    chk("bp_hold_acc",    $signed(b16.acc_out), 32);
    chk("bp_hold_valid",  b16.out_valid, 1);
    b16.out_ready = 1'b1;
    #1;
    chk("bp_release_rdy", b16.in_ready, 1);
    @(negedge clk);
    b16.in_valid = 1'b0;
    chk("bp_swap_valid", b16.out_valid, 1);
    chk("bp_swap_acc",   $signed(b16.acc_out), 144);
    chk("bp_swap_cnt",   b16.term_cnt, 0);
    @(negedge clk);
    chk("bp_drained", b16.out_valid, 0);

    // Throughput: 3 x 16 x (2,2) back-to-back, each result 64
    pulses = 0;
    ready_lows = 0;
    b16.in_valid = 1'b1; b16.act = 8'sd2; b16.wgt = 8'sd2;
    for (int k = 0; k < 48; k++) begin
      if (!b16.in_ready) ready_lows++;
      @(negedge clk);
      chk("tp_valid_pos", b16.out_valid, ((k % 16) == 15) ? 1 : 0);
      if (b16.out_valid) begin
        pulses++;
        chk("tp_acc", $signed(b16.acc_out), 64);
      end
    end
    b16.in_valid = 1'b0;
    chk("tp_pulses",     pulses, 3);
    chk("tp_ready_lows", ready_lows, 0);
    @(negedge clk);

    // Idle gaps: 16 x (1,-1) -> -16, term_cnt steady while idle
    for (int t = 0; t < 16; t++) begin
      int gap;
      gap = (t == 5) ? 3 : int'($urandom_range(0, 2));
      repeat (gap) begin
        @(negedge clk);
        chk("idle_hold_cnt", b16.term_cnt, t);
      end
      push16(8'sd1, -8'sd1);
    end
    chk("idle_valid", b16.out_valid, 1);
    chk("idle_acc",   $signed(b16.acc_out), -16);

    // LEN=256 saturation
    run256(-8'sd128, -8'sd128, 256);
    chk("sat_pos_valid", b256.out_valid, 1);
    chk("sat_pos_acc",   $signed(b256.acc_out), 524287);
    chk("sat_pos_flag",  b256.sat_flag, 1);
    run256(-8'sd128, 8'sd127, 256);
    chk("sat_neg_acc",  $signed(b256.acc_out), -524287);
    chk("sat_neg_flag", b256.sat_flag, 1);
    // Clamp then walk back down: 524287 - 192
    run256(8'sd127, 8'sd127, 64);
    chk("sat_mid_cnt", b256.term_cnt, 64);
    run256(-8'sd1, 8'sd1, 192);
    chk("sat_resume_acc",  $signed(b256.acc_out), 524095);
    chk("sat_resume_flag", b256.sat_flag, 1);
    run256(8'sd1, 8'sd1, 256);
    chk("sat_clear_acc",  $signed(b256.acc_out), 256);
    chk("sat_clear_flag", b256.sat_flag, 0);

    // LEN=1: every pair is final
    b1.in_valid = 1'b1; b1.act = 8'sd7; b1.wgt = -8'sd9;
    @(negedge clk);
    chk("len1_valid", b1.out_valid, 1);
    chk("len1_acc",   $signed(b1.acc_out), -63);
    chk("len1_cnt",   b1.term_cnt, 0);
    b1.act = 8'sd2; b1.wgt = 8'sd3;
    #1;
    chk("len1_stall", b1.in_ready, 0);
    @(negedge clk);
    chk("len1_held", $signed(b1.acc_out), -63);
    b1.out_ready = 1'b1;
    @(negedge clk);
    b1.in_valid = 1'b0;
    chk("len1_swap_valid", b1.out_valid, 1);
    chk("len1_swap_acc",   $signed(b1.acc_out), 6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
